ddr3_int_local_arbiter: RTL and testbench
=========================================

Name: ddr3_int_local_arbiter

Overview:
- Shares the single DDR3 controller local (Avalon-style) port among NUM_REQ requesters, e.g. display fetch, drawing engine and host bridge.
- Round-robin arbitration; a write burst holds the grant until it completes.
- Read tags are tracked in a FIFO so each local_rdata_valid beat is routed back to the requester that issued the read.
- Sits directly between the requester fabric and the controller local_* interface, in the phy_clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 25, local address width
SIZE_W, 6, burst size width in beats
DATA_W, 128, local data width
TAG_DEPTH, 8, outstanding read commands tracked (power of 2)

Ports:
phy_clk  in  1  controller-side clock, all logic rising-edge
reset_phy_clk  in  1  synchronous active-high reset
req_read  in  NUM_REQ  per-requester read request
req_write  in  NUM_REQ  per-requester write request / write-beat valid
req_addr  in  NUM_REQ*ADDR_W  packed addresses
req_size  in  NUM_REQ*SIZE_W  packed burst sizes
req_be  in  NUM_REQ*DATA_W/8  packed byte enables
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot pulse; read command or write beat accepted
req_rdata_valid  out  NUM_REQ  one-hot read-return strobe
req_rdata  out  DATA_W  shared read data (local_rdata passthrough)
local_ready  in  1  controller accepts command/beat
local_rdata_valid  in  1  controller read beat valid
local_rdata  in  DATA_W  controller read data
local_read_req  out  1  to controller
local_write_req  out  1  to controller
local_burstbegin  out  1  first beat of a command
local_address  out  ADDR_W  to controller
local_size  out  SIZE_W  to controller
local_be  out  DATA_W/8  to controller
local_wdata  out  DATA_W  to controller
arb_err_rdata  out  1  sticky: rdata_valid received with no outstanding tag

Behaviour:
- Reset: state IDLE; all local_*_req, local_burstbegin, req_ready, req_rdata_valid and arb_err_rdata at 0; grant=0; RR pointer=0; tag FIFO empty; beat counter 0. Outstanding reads are dropped.
- A requester is eligible if req_write=1, or if req_read=1 and the tag FIFO is not full. req_read and req_write both set: write wins for that requester.
- IDLE:
  - Any eligible requester: register the winner as grant (first eligible at or after the pointer, wrapping) and go to CMD.
  - Set pointer = winner+1 mod NUM_REQ.
  - Latency: req at cycle t gives a local command at t+1.
- CMD:
  - Drive local_* from the granted requester; local_burstbegin=1.
  - Hold all outputs while local_ready=0.
  - On local_ready:
    - Read: push {grant, size} to the tag FIFO; back to IDLE.
    - Write, size<=1: back to IDLE.
    - Write, size>1: load beat_cnt = size-1 and go to WR_BURST.
  - req_ready[grant] pulses in the accept cycle.
- WR_BURST:
  - local_write_req = req_write[grant]; a requester gap stalls the burst and the grant is not released.
  - local_burstbegin=0.
  - Each cycle with local_write_req & local_ready: one beat accepted, req_ready pulses, beat_cnt decrements.
  - beat_cnt reaching 0 gives IDLE.
- req_size=0 is treated as 1.
- Read return:
  - FIFO head gives {id, cnt}. Each local_rdata_valid asserts req_rdata_valid[id] in the same cycle (combinational) and decrements cnt. Pop when cnt hits 0.
  - Push and pop in the same cycle is legal, including when full.
  - local_rdata_valid with the FIFO empty sets arb_err_rdata; the strobe is not forwarded.
- Address, size and data are never modified; width is passed through.

Optional Feature:
- Macro: DDR3_ARB_DISPLAY_PRIO_EN.
- Defined: requester 0 is strict priority. If eligible in IDLE it wins regardless of the pointer, and the pointer is not updated. Requesters 1..NUM_REQ-1 round-robin among themselves.
- Undefined: pure round-robin over all requesters.

Decomposition:
- Package ddr3_arb_pkg: state enum (IDLE, CMD, WR_BURST) and the tag struct {id: clog2(NUM_REQ), cnt: SIZE_W}.
- Sub-module ddr3_int_arb_tag_fifo: synchronous FIFO with full/empty and TAG_DEPTH entries.

Test Plan:
- Req1 read addr 0x100 size 2, local_ready=1 -> local_read_req+burstbegin one cycle later; two rdata_valid beats -> req_rdata_valid=0b0010 twice; FIFO empty after.
- Req0 write size 4, local_ready low 2 cycles in CMD, then high -> outputs stable while stalled; 4 req_ready pulses; burstbegin only on first beat; back to IDLE.
- All 4 requesters reading continuously -> grants 0,1,2,3,0 (round-robin); with DDR3_ARB_DISPLAY_PRIO_EN, req0 wins every arbitration.
- 8 reads issued with no rdata returned -> 9th read held, a concurrent write from another requester still granted; one completed return -> read proceeds.
- local_rdata_valid with nothing outstanding -> arb_err_rdata=1 and stays 1 until reset; no req_rdata_valid.
- reset_phy_clk asserted mid WR_BURST (beat 2 of 4) -> next cycle all req outputs 0, state IDLE, FIFO empty.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: shared types for the DDR3 local-port arbiter.
// The tag fields are sized for the largest supported configuration
// (8 requesters, 16-bit burst counts). Narrower designs zero-extend into them.
package ddr3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WR_BURST = 2'd2
  } arb_state_t;

  localparam int TAG_ID_W  = 3;
  localparam int TAG_CNT_W = 16;

  // One outstanding read: who issued it and how many beats it returns.
  typedef struct packed {
    logic [TAG_ID_W-1:0]  id;
    logic [TAG_CNT_W-1:0] cnt;
  } tag_t;

endpackage

// File: rtl/ddr3_int_arb_tag_fifo.sv
// ddr3_int_arb_tag_fifo: synchronous FIFO of read tags with full/empty.
// A push is accepted while full when a pop happens in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module ddr3_int_arb_tag_fifo
  import ddr3_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Tag storage write port.
  // NOTE: storage is deliberately not reset; count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  // Pointer and occupancy tracking.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_int_local_arbiter.sv
// ddr3_int_local_arbiter: shares the DDR3 controller local port among
// NUM_REQ requesters with round-robin arbitration. Write bursts keep the
// grant until their last beat; read tags route returned beats back.
// Optional macro DDR3_ARB_DISPLAY_PRIO_EN: requester 0 gets strict priority
// and the others round-robin among themselves.
module ddr3_int_local_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 25,
  parameter int SIZE_W    = 6,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 8
) (
  input  logic                          phy_clk,
  input  logic                          reset_phy_clk,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*SIZE_W-1:0]     req_size,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_be,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_rdata_valid,
  output logic [DATA_W-1:0]             req_rdata,
  input  logic                          local_ready,
  input  logic                          local_rdata_valid,
  input  logic [DATA_W-1:0]             local_rdata,
  output logic                          local_read_req,
  output logic                          local_write_req,
  output logic                          local_burstbegin,
  output logic [ADDR_W-1:0]             local_address,
  output logic [SIZE_W-1:0]             local_size,
  output logic [DATA_W/8-1:0]           local_be,
  output logic [DATA_W-1:0]             local_wdata,
  output logic                          arb_err_rdata
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BE_W = DATA_W / 8;

  arb_state_t           state, state_nxt;
  logic [ID_W-1:0]      grant, grant_nxt;
  logic [ID_W-1:0]      ptr, ptr_nxt;
  logic [ID_W-1:0]      win_id;
  logic                 win_valid;
  logic                 prio_win;
  logic                 grant_wr, grant_wr_nxt;
  logic [SIZE_W-1:0]    beat_cnt, beat_cnt_nxt;
  logic [SIZE_W-1:0]    eff_size;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   rr_elig;
  logic                 tag_push, tag_pop, tag_full, tag_empty;
  logic                 rd_hit;
  tag_t                 push_tag, head_tag;
  logic [TAG_CNT_W-1:0] rd_used;
  logic                 err_q;

  // A read needs a free tag slot; a write is always eligible and wins over a read.
  assign elig = req_write | (req_read & {NUM_REQ{~tag_full}});

`ifdef DDR3_ARB_DISPLAY_PRIO_EN
  assign prio_win = elig[0];
  assign rr_elig  = elig & ~NUM_REQ'(1);
`else
  assign prio_win = 1'b0;
  assign rr_elig  = elig;
`endif

  // Round-robin search: first eligible requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    win_valid = prio_win;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_valid && rr_elig[idx]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Command fields come straight from the granted requester, unmodified.
  always_comb begin
    int g;
    g             = int'(grant);
    local_address = req_addr[g*ADDR_W +: ADDR_W];
    local_size    = req_size[g*SIZE_W +: SIZE_W];
    local_be      = req_be[g*BE_W +: BE_W];
    local_wdata   = req_wdata[g*DATA_W +: DATA_W];
  end

  // A zero-length burst behaves as a single beat.
  assign eff_size = (local_size == '0) ? SIZE_W'(1) : local_size;

  // Next-state and local-port handshake.
  always_comb begin
    state_nxt        = state;
    grant_nxt        = grant;
    grant_wr_nxt     = grant_wr;
    ptr_nxt          = ptr;
    beat_cnt_nxt     = beat_cnt;
    local_read_req   = 1'b0;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    req_ready        = '0;
    tag_push         = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          grant_nxt    = win_id;
          grant_wr_nxt = req_write[win_id];
          state_nxt    = CMD;
          if (!prio_win) begin
            ptr_nxt = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
          end
        end
      end
      CMD: begin
        local_burstbegin = 1'b1;
        local_read_req   = ~grant_wr;
        local_write_req  = grant_wr;
        if (local_ready) begin
          req_ready[grant] = 1'b1;
          if (!grant_wr) begin
            tag_push  = 1'b1;
            state_nxt = IDLE;
          end else if (eff_size == SIZE_W'(1)) begin
            state_nxt = IDLE;
          end else begin
            beat_cnt_nxt = eff_size - 1'b1;
            state_nxt    = WR_BURST;
          end
        end
      end
      WR_BURST: begin
        // A requester gap simply stalls the burst; the grant stays put.
        local_write_req = req_write[grant];
        if (req_write[grant] && local_ready) begin
          req_ready[grant] = 1'b1;
          beat_cnt_nxt     = beat_cnt - 1'b1;
          if (beat_cnt == SIZE_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      state    <= IDLE;
      grant    <= '0;
      grant_wr <= 1'b0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_wr <= grant_wr_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  assign push_tag = '{id: TAG_ID_W'(grant), cnt: TAG_CNT_W'(eff_size)};

  ddr3_int_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (phy_clk),
    .rst      (reset_phy_clk),
    .push     (tag_push),
    .push_tag (push_tag),
    .pop      (tag_pop),
    .head     (head_tag),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // Returned beats belong to the oldest tag; the last beat retires it.
  assign rd_hit    = local_rdata_valid & ~tag_empty;
  assign tag_pop   = rd_hit & ((rd_used + 1'b1) == head_tag.cnt);
  assign req_rdata = local_rdata;

  // Route the read strobe to the owner of the head tag.
  always_comb begin
    req_rdata_valid = '0;
    if (rd_hit) req_rdata_valid = NUM_REQ'(1) << head_tag.id;
  end

  // Beat count within the head tag and the sticky orphan-data flag.
  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      rd_used <= '0;
      err_q   <= 1'b0;
    end else begin
      if (tag_pop)     rd_used <= '0;
      else if (rd_hit) rd_used <= rd_used + 1'b1;
      if (local_rdata_valid && tag_empty) err_q <= 1'b1;
    end
  end

  assign arb_err_rdata = err_q;

endmodule

// File: tb/tb_ddr3_int_local_arbiter.sv
// tb_ddr3_int_local_arbiter: directed bench for ddr3_int_local_arbiter.
// Honours DDR3_ARB_DISPLAY_PRIO_EN for the arbitration-order expectations.
module tb_ddr3_int_local_arbiter;

  logic         phy_clk;
  logic         reset_phy_clk;
  logic [3:0]   req_read, req_write, req_ready, req_rdata_valid;
  logic [99:0]  req_addr;
  logic [23:0]  req_size;
  logic [63:0]  req_be;
  logic [511:0] req_wdata;
  logic [127:0] req_rdata, local_rdata, local_wdata;
  logic         local_ready, local_rdata_valid;
  logic         local_read_req, local_write_req, local_burstbegin;
  logic [24:0]  local_address;
  logic [5:0]   local_size;
  logic [15:0]  local_be;
  logic         arb_err_rdata;

  int errors = 0;
  int checks = 0;

  ddr3_int_local_arbiter dut (
    .phy_clk           (phy_clk),
    .reset_phy_clk     (reset_phy_clk),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_size          (req_size),
    .req_be            (req_be),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .req_rdata_valid   (req_rdata_valid),
    .req_rdata         (req_rdata),
    .local_ready       (local_ready),
    .local_rdata_valid (local_rdata_valid),
    .local_rdata       (local_rdata),
    .local_read_req    (local_read_req),
    .local_write_req   (local_write_req),
    .local_burstbegin  (local_burstbegin),
    .local_address     (local_address),
    .local_size        (local_size),
    .local_be          (local_be),
    .local_wdata       (local_wdata),
    .arb_err_rdata     (arb_err_rdata)
  );

  initial phy_clk = 1'b0;
  always #5 phy_clk = ~phy_clk;

  // Drive point: just after the rising edge.
  task automatic cyc();
    @(posedge phy_clk);
    #1;
  endtask

  // Sample point: well clear of both edges.
  task automatic settle();
    #2;
  endtask

  task automatic clr_reqs();
    req_read          = '0;
    req_write         = '0;
    local_ready       = 1'b0;
    local_rdata_valid = 1'b0;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr,
                         input logic [24:0] addr, input logic [5:0] size);
    req_read[i]              = rd;
    req_write[i]             = wr;
    req_addr[i*25 +: 25]     = addr;
    req_size[i*6 +: 6]       = size;
    req_be[i*16 +: 16]       = 16'hF0F0 ^ 16'(i);
    req_wdata[i*128 +: 128]  = {4{32'hC0DE_0000 | 32'(i)}};
  endtask

  task automatic do_reset();
    reset_phy_clk = 1'b1;
    clr_reqs();
    cyc();
    cyc();
    reset_phy_clk = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (local_read_req !== 1'b0)   begin errors++; $display("FAIL rst_read_req: got %b want 0", local_read_req); end
    checks++; if (local_write_req !== 1'b0)  begin errors++; $display("FAIL rst_write_req: got %b want 0", local_write_req); end
    checks++; if (local_burstbegin !== 1'b0) begin errors++; $display("FAIL rst_burstbegin: got %b want 0", local_burstbegin); end
    checks++; if (req_ready !== 4'b0)        begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    checks++; if (req_rdata_valid !== 4'b0)  begin errors++; $display("FAIL rst_rdata_valid: got %b want 0000", req_rdata_valid); end
    checks++; if (arb_err_rdata !== 1'b0)    begin errors++; $display("FAIL rst_err: got %b want 0", arb_err_rdata); end
  endtask

  task automatic test_read_return();
    do_reset();
    set_req(1, 1'b1, 1'b0, 25'h100, 6'd2);
    local_ready = 1'b1;
    settle();
    checks++; if (local_read_req !== 1'b0) begin errors++; $display("FAIL rd_lat0: got %b want 0", local_read_req); end
    cyc(); settle();
    checks++; if (local_read_req !== 1'b1)   begin errors++; $display("FAIL rd_cmd_req: got %b want 1", local_read_req); end
    checks++; if (local_write_req !== 1'b0)  begin errors++; $display("FAIL rd_cmd_wr: got %b want 0", local_write_req); end
    checks++; if (local_burstbegin !== 1'b1) begin errors++; $display("FAIL rd_cmd_bb: got %b want 1", local_burstbegin); end
    checks++; if (local_address !== 25'h100) begin errors++; $display("FAIL rd_cmd_addr: got %h want 100", local_address); end
    checks++; if (local_size !== 6'd2)       begin errors++; $display("FAIL rd_cmd_size: got %0d want 2", local_size); end
    checks++; if (req_ready !== 4'b0010)     begin errors++; $display("FAIL rd_cmd_ready: got %b want 0010", req_ready); end
    cyc();
    req_read[1] = 1'b0;
    settle();
    checks++; if (local_read_req !== 1'b0) begin errors++; $display("FAIL rd_back_idle: got %b want 0", local_read_req); end
    local_rdata       = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    local_rdata_valid = 1'b1;
    settle();
    checks++; if (req_rdata_valid !== 4'b0010) begin errors++; $display("FAIL rd_beat1: got %b want 0010", req_rdata_valid); end
    checks++; if (req_rdata !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin errors++; $display("FAIL rd_data: got %h want 11112222333344445555666677778888", req_rdata); end
    cyc(); settle();
    checks++; if (req_rdata_valid !== 4'b0010) begin errors++; $display("FAIL rd_beat2: got %b want 0010", req_rdata_valid); end
    cyc(); settle();
    checks++; if (req_rdata_valid !== 4'b0000) begin errors++; $display("FAIL rd_fifo_empty: got %b want 0000", req_rdata_valid); end
    cyc();
    local_rdata_valid = 1'b0;
    settle();
    checks++; if (arb_err_rdata !== 1'b1) begin errors++; $display("FAIL rd_extra_err: got %b want 1", arb_err_rdata); end
  endtask

  task automatic test_size_zero();
    logic seen2, seen3;
    do_reset();
    set_req(2, 1'b1, 1'b0, 25'h300, 6'd0);
    set_req(3, 1'b1, 1'b0, 25'h340, 6'd1);
    local_ready = 1'b1;
    seen2 = 1'b0;
    seen3 = 1'b0;
    for (int c = 0; c < 12 && !(seen2 && seen3); c++) begin
      cyc(); settle();
      if (req_ready[2]) begin seen2 = 1'b1; req_read[2] = 1'b0; end
      if (req_ready[3]) begin seen3 = 1'b1; req_read[3] = 1'b0; end
    end
    checks++; if (!(seen2 && seen3)) begin errors++; $display("FAIL sz0_grants: got %b%b want 11", seen2, seen3); end
    local_rdata_valid = 1'b1;
    settle();
    checks++; if (req_rdata_valid !== 4'b0100) begin errors++; $display("FAIL sz0_beat_req2: got %b want 0100", req_rdata_valid); end
    cyc(); settle();
    checks++; if (req_rdata_valid !== 4'b1000) begin errors++; $display("FAIL sz0_beat_req3: got %b want 1000", req_rdata_valid); end
    cyc();
    local_rdata_valid = 1'b0;
    settle();
    checks++; if (arb_err_rdata !== 1'b0) begin errors++; $display("FAIL sz0_no_err: got %b want 0", arb_err_rdata); end
  endtask

  task automatic test_write_stall();
    int nready, nbb;
    do_reset();
    set_req(0, 1'b0, 1'b1, 25'h200, 6'd4);
    local_ready = 1'b0;
    cyc(); settle();
    checks++; if (local_write_req !== 1'b1)  begin errors++; $display("FAIL wr_cmd_req: got %b want 1", local_write_req); end
    checks++; if (local_burstbegin !== 1'b1) begin errors++; $display("FAIL wr_cmd_bb: got %b want 1", local_burstbegin); end
    checks++; if (local_be !== 16'hF0F0)     begin errors++; $display("FAIL wr_cmd_be: got %h want f0f0", local_be); end
    checks++; if (local_wdata !== {4{32'hC0DE_0000}}) begin errors++; $display("FAIL wr_cmd_wdata: got %h want c0de0000 x4", local_wdata); end
    checks++; if (req_ready !== 4'b0000)     begin errors++; $display("FAIL wr_stall_ready: got %b want 0000", req_ready); end
    cyc(); settle();
    checks++; if (local_write_req !== 1'b1 || local_burstbegin !== 1'b1 || local_address !== 25'h200 || local_size !== 6'd4)
      begin errors++; $display("FAIL wr_stall_hold: got wr=%b bb=%b addr=%h size=%0d want 1 1 200 4", local_write_req, local_burstbegin, local_address, local_size); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wr_stall_ready2: got %b want 0000", req_ready); end
    local_ready = 1'b1;
    settle();
    nready = 0;
    nbb    = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin cyc(); settle(); end
      if (req_ready[0]) nready++;
      if (req_ready[0] && local_burstbegin) nbb++;
      if (nready == 4) begin req_write[0] = 1'b0; break; end
    end
    checks++; if (nready != 4) begin errors++; $display("FAIL wr_beats: got %0d want 4", nready); end
    checks++; if (nbb != 1)    begin errors++; $display("FAIL wr_bb_count: got %0d want 1", nbb); end
    cyc(); settle();
    checks++; if (local_write_req !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL wr_done_idle: got wr=%b ready=%b want 0 0000", local_write_req, req_ready); end
  endtask

  task automatic test_wr_gap();
    do_reset();
    set_req(0, 1'b0, 1'b1, 25'h400, 6'd2);
    set_req(2, 1'b1, 1'b0, 25'h440, 6'd1);
    local_ready = 1'b1;
    cyc(); settle();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL gap_first: got %b want 0001", req_ready); end
    cyc();
    req_write[0] = 1'b0;
    settle();
    checks++; if (local_write_req !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL gap_stall: got wr=%b ready=%b want 0 0000", local_write_req, req_ready); end
    cyc(); settle();
    checks++; if (local_read_req !== 1'b0) begin errors++; $display("FAIL gap_grant_held: got %b want 0", local_read_req); end
    req_write[0] = 1'b1;
    settle();
    checks++; if (local_write_req !== 1'b1 || req_ready !== 4'b0001) begin errors++; $display("FAIL gap_resume: got wr=%b ready=%b want 1 0001", local_write_req, req_ready); end
    cyc();
    req_write[0] = 1'b0;
    cyc(); settle();
    checks++; if (local_read_req !== 1'b1 || req_ready !== 4'b0100 || local_address !== 25'h440)
      begin errors++; $display("FAIL gap_next_read: got rd=%b ready=%b addr=%h want 1 0100 440", local_read_req, req_ready, local_address); end
    req_read[2] = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] got [5];
    logic [3:0] exp [5];
    int n;
`ifdef DDR3_ARB_DISPLAY_PRIO_EN
    exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 25'(i * 16), 6'd1);
    local_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) got[i] = '0;
    for (int c = 0; c < 24 && n < 5; c++) begin
      cyc(); settle();
      if (req_ready != 4'b0) begin got[n] = req_ready; n++; end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL rr_count: got %0d want 5", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", i, got[i], exp[i]); end
    end
    clr_reqs();
  endtask

  task automatic test_fifo_full();
    int n, bad;
    logic found;
    do_reset();
    set_req(1, 1'b1, 1'b0, 25'h500, 6'd1);
    local_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      cyc(); settle();
      if (req_ready[1]) n++;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL full_fill: got %0d want 8", n); end
    set_req(2, 1'b0, 1'b1, 25'h600, 6'd1);
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      cyc(); settle();
      if (req_ready != 4'b0) begin
        found = 1'b1;
        checks++; if (req_ready !== 4'b0100 || local_write_req !== 1'b1) begin errors++; $display("FAIL full_write_grant: got ready=%b wr=%b want 0100 1", req_ready, local_write_req); end
        req_write[2] = 1'b0;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL full_write_timeout: got none want grant"); end
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(); settle();
      if (local_read_req !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_read_held: got %0d read cycles want 0", bad); end
    local_rdata_valid = 1'b1;
    settle();
    checks++; if (req_rdata_valid !== 4'b0010) begin errors++; $display("FAIL full_return: got %b want 0010", req_rdata_valid); end
    cyc();
    local_rdata_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      settle();
      if (req_ready[1]) found = 1'b1;
      cyc();
    end
    checks++; if (!found) begin errors++; $display("FAIL full_read_resume: got none want req1 grant"); end
    clr_reqs();
  endtask

  task automatic test_err();
    do_reset();
    local_rdata_valid = 1'b1;
    settle();
    checks++; if (req_rdata_valid !== 4'b0) begin errors++; $display("FAIL err_no_strobe: got %b want 0000", req_rdata_valid); end
    cyc();
    local_rdata_valid = 1'b0;
    settle();
    checks++; if (arb_err_rdata !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", arb_err_rdata); end
    cyc(); cyc(); cyc(); settle();
    checks++; if (arb_err_rdata !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", arb_err_rdata); end
    do_reset();
    settle();
    checks++; if (arb_err_rdata !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", arb_err_rdata); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(1, 1'b1, 1'b0, 25'h700, 6'd1);
    local_ready = 1'b1;
    cyc();
    req_read[1] = 1'b0;
    cyc();
    set_req(0, 1'b0, 1'b1, 25'h800, 6'd4);
    cyc(); settle();
    checks++; if (req_ready !== 4'b0001 || local_burstbegin !== 1'b1) begin errors++; $display("FAIL mid_beat1: got ready=%b bb=%b want 0001 1", req_ready, local_burstbegin); end
    cyc(); settle();
    checks++; if (req_ready !== 4'b0001 || local_burstbegin !== 1'b0) begin errors++; $display("FAIL mid_beat2: got ready=%b bb=%b want 0001 0", req_ready, local_burstbegin); end
    reset_phy_clk = 1'b1;
    cyc(); settle();
    checks++; if (local_write_req !== 1'b0 || local_read_req !== 1'b0 || local_burstbegin !== 1'b0 || req_ready !== 4'b0 || req_rdata_valid !== 4'b0)
      begin errors++; $display("FAIL mid_rst_outputs: got wr=%b rd=%b bb=%b ready=%b rv=%b want all 0", local_write_req, local_read_req, local_burstbegin, req_ready, req_rdata_valid); end
    reset_phy_clk     = 1'b0;
    req_write[0]      = 1'b0;
    local_rdata_valid = 1'b1;
    settle();
    checks++; if (req_rdata_valid !== 4'b0) begin errors++; $display("FAIL mid_rst_tag_dropped: got %b want 0000", req_rdata_valid); end
    cyc();
    local_rdata_valid = 1'b0;
    req_write[0]      = 1'b1;
    settle();
    checks++; if (arb_err_rdata !== 1'b1 || local_write_req !== 1'b0) begin errors++; $display("FAIL mid_rst_idle: got err=%b wr=%b want 1 0", arb_err_rdata, local_write_req); end
    cyc(); settle();
    checks++; if (local_burstbegin !== 1'b1 || local_write_req !== 1'b1 || req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rst_restart: got bb=%b wr=%b ready=%b want 1 1 0001", local_burstbegin, local_write_req, req_ready); end
    clr_reqs();
  endtask

  initial begin
    reset_phy_clk     = 1'b1;
    req_read          = '0;
    req_write         = '0;
    req_addr          = '0;
    req_size          = '0;
    req_be            = '0;
    req_wdata         = '0;
    local_ready       = 1'b0;
    local_rdata_valid = 1'b0;
    local_rdata       = '0;
    test_reset();
    test_read_return();
    test_size_zero();
    test_write_stall();
    test_wr_gap();
    test_round_robin();
    test_fifo_full();
    test_err();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
